// File: rtl/csel_iter_adder_pkg.sv
// Shared definitions for the iterative carry-select adder: FSM state encoding
// and default operand / block widths.
package csel_iter_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_BLOCK = 8;

endpackage

// File: rtl/csel_iter_adder_block.sv
// Combinational carry-select slice: forms both candidate sums of one block and
// picks one with the incoming carry.
module csel_iter_adder_block #(
    parameter int BLOCK = 8
) (
    input  logic [BLOCK-1:0] a_blk,
    input  logic [BLOCK-1:0] b_blk,
    input  logic             sel_carry,
    output logic [BLOCK-1:0] sum_blk,
    output logic             cout
);

    logic [BLOCK:0] s0;
    logic [BLOCK:0] s1;

    // Both candidates are built in parallel so only a 2:1 select sits behind the carry.
    assign s0 = {1'b0, a_blk} + {1'b0, b_blk};
    assign s1 = {1'b0, a_blk} + {1'b0, b_blk} + (BLOCK + 1)'(1);

    assign {cout, sum_blk} = sel_carry ? s1 : s0;

endmodule

// File: rtl/csel_iter_adder.sv
// Multi-cycle carry-select adder: resolves BLOCK bits of a WIDTH-bit sum per
// clock and presents a registered {carry_out, sum} word with a done pulse.
module csel_iter_adder
    import csel_iter_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BLOCK = DEF_BLOCK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   result
);

    localparam int NB = WIDTH / BLOCK;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NB - 1);

    if (WIDTH % BLOCK != 0) begin : g_width_check
        $error("csel_iter_adder: WIDTH must be a multiple of BLOCK");
    end

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [CW-1:0]    cnt;

    logic [BLOCK-1:0] a_blk;
    logic [BLOCK-1:0] b_blk;
    logic [BLOCK-1:0] sum_blk;
    logic             blk_cout;
    logic             accept;

    assign accept = start && (state == ST_IDLE || state == ST_DONE);
    assign a_blk  = a_r[int'(cnt) * BLOCK +: BLOCK];
    assign b_blk  = b_r[int'(cnt) * BLOCK +: BLOCK];

    csel_iter_adder_block #(
        .BLOCK (BLOCK)
    ) u_block (
        .a_blk     (a_blk),
        .b_blk     (b_blk),
        .sel_carry (carry_r),
        .sum_blk   (sum_blk),
        .cout      (blk_cout)
    );

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (cnt == LAST_IDX) state_next = ST_DONE;
            ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order in this block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next == ST_RUN);
            done  <= (state_next == ST_DONE);

            if (accept) begin
                a_r     <= a;
                b_r     <= b;
                carry_r <= cin;
                result  <= '0;
                cnt     <= '0;
            end else if (state == ST_RUN) begin
                result[int'(cnt) * BLOCK +: BLOCK] <= sum_blk;
                carry_r <= blk_cout;
                cnt     <= cnt + 1'b1;
                // The final block's carry becomes the adder's carry-out.
                if (cnt == LAST_IDX) result[WIDTH] <= blk_cout;
            end
        end
    end

endmodule

// File: tb/tb_csel_iter_adder.sv
// Self-checking bench for csel_iter_adder: directed corner cases plus random
// operands against a plain-arithmetic reference sum.
module tb_csel_iter_adder;

    localparam int WIDTH = 32;
    localparam int BLOCK = 8;
    localparam int NB    = WIDTH / BLOCK;
    localparam int BOUND = 40;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   result;

    int n_checks = 0;
    int n_pass   = 0;

    csel_iter_adder #(
        .WIDTH (WIDTH),
        .BLOCK (BLOCK)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic c);
        longint unsigned s;
        s = longint'(x) + longint'(y) + longint'(c);
        return s[WIDTH:0];
    endfunction

    // Called at a negedge; issues start for one cycle, optionally pokes start
    // with zero operands at RUN cycle index 'poke', and returns at the negedge
    // of the done cycle.
    task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                         input logic tc, input int poke, input string tag);
        int lat;
        int busy_n;
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; cin = 1'($urandom);
        lat = 0;
        busy_n = 0;
        while (!done && lat < BOUND) begin
            if (busy) busy_n++;
            if (lat == poke) begin
                start = 1'b1; a = '0; b = '0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'(NB));
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'(NB));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_result"}, 64'(result), 64'(ref_sum(ta, tb_v, tc)));
    endtask

    initial begin
        int dn;
        logic [WIDTH:0] held;
        logic [WIDTH-1:0] ra, rb;
        logic rc;

        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        reset = 1'b0;
        dn = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("idle_no_done", 64'(dn), 64'd0);

        do_op(32'h0000_0001, 32'h0000_0002, 1'b0, -1, "small");
        check("small_const", 64'(result), 64'h0_0000_0003);
        held = result;
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        check("result_held", 64'(result), 64'(held));

        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, -1, "ripple");
        check("ripple_const", 64'(result), 64'h1_0000_0000);
        @(negedge clk);

        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, -1, "allones");
        check("allones_const", 64'(result), 64'h1_FFFF_FFFF);
        do_op(32'd5, 32'd7, 1'b0, -1, "b2b");
        check("b2b_const", 64'(result), 64'h0_0000_000C);
        @(negedge clk);

        do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1, "ignore");
        check("ignore_const", 64'(result), 64'h0_2345_6789);
        @(negedge clk);
        check("ignore_no_restart", 64'(busy), 64'd0);

        // Reset abandons an operation mid-RUN.
        a = 32'hDEAD_BEEF; b = 32'h1234_5678; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        check("midreset_result", 64'(result), 64'd0);
        dn = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("midreset_no_done", 64'(dn), 64'd0);

        // Reset and start together: start is dropped.
        reset = 1'b1; start = 1'b1; a = 32'd1; b = 32'd1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("reset_beats_start", 64'(busy), 64'd0);

        do_op(32'h8000_0000, 32'h8000_0000, 1'b0, -1, "msb");
        check("msb_const", 64'(result), 64'h1_0000_0000);
        @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom);
            if (i % 5 == 0) rb = ~ra;
            do_op(ra, rb, rc, -1, "rand");
            if ($urandom_range(1, 0) == 1) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
